// File: rtl/grid_stream_loader.sv
// Loads an ASCII '@'/'.' grid from a valid/ready byte stream into a WIDTH x DEPTH bit matrix.
// Grid is presented one cycle after its terminating byte; in_ready stays low until grid_ack.
module grid_stream_loader #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               in_valid,
  input  logic [7:0]                         in_data,
  output logic                               in_ready,
  output logic                               grid_valid,
  input  logic                               grid_ack,
  output logic [WIDTH*DEPTH-1:0]             mat_flat,
  output logic [$clog2(DEPTH+1)-1:0]         rows,
  output logic [$clog2(WIDTH+1)-1:0]         cols,
  output logic [$clog2(WIDTH*DEPTH+1)-1:0]   paper_count,
  output logic                               error
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int RW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(WIDTH * DEPTH + 1);
  localparam int IW = $clog2(WIDTH * DEPTH);

  localparam logic [7:0] CH_PAPER = 8'h40;
  localparam logic [7:0] CH_EMPTY = 8'h2E;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_EOT   = 8'h04;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    DONE = 2'd1,
    ERR  = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [WIDTH*DEPTH-1:0]   mat_q, mat_d;
  logic [CW-1:0]            col_q, col_d;
  logic [RW-1:0]            row_q, row_d;
  logic [CW-1:0]            cols_q, cols_d;
  logic [PW-1:0]            paper_q, paper_d;

  logic                     accept;
  logic                     row_nonempty;
  logic                     close_ok;
  logic [RW-1:0]            row_inc;
  logic [IW-1:0]            bit_idx;

  always_comb begin
    state_d      = state_q;
    mat_d        = mat_q;
    col_d        = col_q;
    row_d        = row_q;
    cols_d       = cols_q;
    paper_d      = paper_q;

    accept       = in_valid && (state_q == LOAD);
    row_nonempty = (col_q != '0);
    // First row defines the width; every later row must match it exactly.
    close_ok     = (row_q == '0) || (col_q == cols_q);
    row_inc      = row_q + RW'(1);
    bit_idx      = IW'(row_q) * IW'(WIDTH) + IW'(col_q);

    case (state_q)
      LOAD: begin
        if (accept) begin
          case (in_data)
            CH_PAPER, CH_EMPTY: begin
              if (col_q == CW'(WIDTH)) begin
                state_d = ERR;
              end else begin
                mat_d[bit_idx] = (in_data == CH_PAPER);
                col_d          = col_q + CW'(1);
                if (in_data == CH_PAPER) begin
                  paper_d = paper_q + PW'(1);
                end
              end
            end
            CH_CR: begin
            end
            CH_LF: begin
              if (!row_nonempty) begin
                if (row_q != '0) begin
                  state_d = DONE;
                end
              end else if (!close_ok) begin
                state_d = ERR;
              end else begin
                if (row_q == '0) begin
                  cols_d = col_q;
                end
                row_d = row_inc;
                col_d = '0;
                if (row_inc == RW'(DEPTH)) begin
                  state_d = DONE;
                end
              end
            end
            CH_EOT: begin
              if (row_nonempty && !close_ok) begin
                state_d = ERR;
              end else begin
                if (row_nonempty) begin
                  if (row_q == '0) begin
                    cols_d = col_q;
                  end
                  row_d = row_inc;
                  col_d = '0;
                end
                // An EOT with no completed row is an empty grid.
                if (row_nonempty || (row_q != '0)) begin
                  state_d = DONE;
                end else begin
                  state_d = ERR;
                end
              end
            end
            default: begin
              state_d = ERR;
            end
          endcase
        end
      end
      DONE, ERR: begin
        if (grid_ack) begin
          state_d = LOAD;
          mat_d   = '0;
          col_d   = '0;
          row_d   = '0;
          cols_d  = '0;
          paper_d = '0;
        end
      end
      default: begin
        state_d = LOAD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= LOAD;
      mat_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
      cols_q  <= '0;
      paper_q <= '0;
    end else begin
      state_q <= state_d;
      mat_q   <= mat_d;
      col_q   <= col_d;
      row_q   <= row_d;
      cols_q  <= cols_d;
      paper_q <= paper_d;
    end
  end

  assign in_ready    = (state_q == LOAD);
  assign grid_valid  = (state_q == DONE);
  assign error       = (state_q == ERR);
  assign mat_flat    = mat_q;
  assign rows        = row_q;
  assign cols        = cols_q;
  assign paper_count = paper_q;

endmodule

// File: tb/tb_grid_stream_loader.sv
// Directed bench for grid_stream_loader: inputs driven on the falling edge, outputs checked
// on the following falling edge.
module tb_grid_stream_loader;

  localparam int W = 16;
  localparam int D = 16;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic [7:0]     in_data;
  logic           in_ready;
  logic           grid_valid;
  logic           grid_ack;
  logic [W*D-1:0] mat_flat;
  logic [4:0]     rows;
  logic [4:0]     cols;
  logic [8:0]     paper_count;
  logic           error;

  int vecs = 0;
  int errs = 0;

  grid_stream_loader #(.WIDTH(W), .DEPTH(D)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .grid_valid  (grid_valid),
    .grid_ack    (grid_ack),
    .mat_flat    (mat_flat),
    .rows        (rows),
    .cols        (cols),
    .paper_count (paper_count),
    .error       (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic send_byte(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic pulse_ack();
    grid_ack = 1'b1;
    @(negedge clk);
    grid_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vecs++;
    if ({grid_valid, error, in_ready} !== 3'b001) begin
      errs++; $display("FAIL rst_flags got %b exp 001", {grid_valid, error, in_ready});
    end
    vecs++;
    if (mat_flat !== '0) begin errs++; $display("FAIL rst_mat got %h exp 0", mat_flat); end
    vecs++;
    if ({rows, cols, paper_count} !== 19'd0) begin
      errs++; $display("FAIL rst_counts got rows=%0d cols=%0d paper=%0d exp 0", rows, cols, paper_count);
    end
    rst_n = 1'b1;
    @(negedge clk);
    vecs++;
    if (in_ready !== 1'b1) begin errs++; $display("FAIL rst_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_basic(input string tag);
    logic [W*D-1:0] e;
    e = '0;
    e[0] = 1'b1; e[2] = 1'b1; e[W+1] = 1'b1; e[2*W] = 1'b1; e[2*W+2] = 1'b1;
    send_str("@.@\n.@.\n@.@\n");
    vecs++;
    if (grid_valid !== 1'b0 || rows !== 5'd3) begin
      errs++; $display("FAIL %s_pre got gv=%b rows=%0d exp gv=0 rows=3", tag, grid_valid, rows);
    end
    send_str("\n");
    vecs++;
    if (grid_valid !== 1'b1 || in_ready !== 1'b0) begin
      errs++; $display("FAIL %s_gv got gv=%b rdy=%b exp gv=1 rdy=0", tag, grid_valid, in_ready);
    end
    vecs++;
    if (rows !== 5'd3 || cols !== 5'd3) begin
      errs++; $display("FAIL %s_dims got %0dx%0d exp 3x3", tag, rows, cols);
    end
    vecs++;
    if (paper_count !== 9'd5) begin errs++; $display("FAIL %s_paper got %0d exp 5", tag, paper_count); end
    vecs++;
    if (mat_flat !== e) begin errs++; $display("FAIL %s_mat got %h exp %h", tag, mat_flat, e); end
    pulse_ack();
    vecs++;
    if (grid_valid !== 1'b0 || in_ready !== 1'b1 || mat_flat !== '0 || rows !== 5'd0 || cols !== 5'd0) begin
      errs++; $display("FAIL %s_clear got gv=%b rdy=%b rows=%0d cols=%0d exp 0 1 0 0", tag, grid_valid, in_ready, rows, cols);
    end
  endtask

  task automatic test_ragged();
    send_str("@@\n@@@");
    vecs++;
    if (error !== 1'b0) begin errs++; $display("FAIL ragged_early got %b exp 0", error); end
    send_str("\n");
    vecs++;
    if (error !== 1'b1 || in_ready !== 1'b0 || grid_valid !== 1'b0) begin
      errs++; $display("FAIL ragged_err got err=%b rdy=%b gv=%b exp 1 0 0", error, in_ready, grid_valid);
    end
    pulse_ack();
    vecs++;
    if (error !== 1'b0 || in_ready !== 1'b1 || mat_flat !== '0) begin
      errs++; $display("FAIL ragged_ack got err=%b rdy=%b mat=%h exp 0 1 0", error, in_ready, mat_flat);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < W; i++) send_byte(8'h40);
    vecs++;
    if (error !== 1'b0 || paper_count !== 9'd16) begin
      errs++; $display("FAIL ovf_16 got err=%b paper=%0d exp 0 16", error, paper_count);
    end
    send_byte(8'h40);
    vecs++;
    if (error !== 1'b1 || in_ready !== 1'b0) begin
      errs++; $display("FAIL ovf_err got err=%b rdy=%b exp 1 0", error, in_ready);
    end
    vecs++;
    if (mat_flat[2*W-1:W] !== '0 || mat_flat[W-1:0] !== '1) begin
      errs++; $display("FAIL ovf_bits got row1=%h row0=%h exp 0000 ffff", mat_flat[2*W-1:W], mat_flat[W-1:0]);
    end
    pulse_ack();
    vecs++;
    if (error !== 1'b0 || mat_flat !== '0 || paper_count !== 9'd0) begin
      errs++; $display("FAIL ovf_ack got err=%b paper=%0d exp 0 0", error, paper_count);
    end
  endtask

  task automatic test_full();
    for (int r = 0; r < D; r++) begin
      for (int c = 0; c < W; c++) send_byte(8'h40);
      send_byte(8'h0A);
      if (r == D - 2) begin
        vecs++;
        if (grid_valid !== 1'b0 || rows !== 5'd15) begin
          errs++; $display("FAIL full_15 got gv=%b rows=%0d exp 0 15", grid_valid, rows);
        end
      end
    end
    vecs++;
    if (grid_valid !== 1'b1 || rows !== 5'd16 || cols !== 5'd16) begin
      errs++; $display("FAIL full_done got gv=%b rows=%0d cols=%0d exp 1 16 16", grid_valid, rows, cols);
    end
    vecs++;
    if (paper_count !== 9'd256 || mat_flat !== '1) begin
      errs++; $display("FAIL full_paper got %0d exp 256", paper_count);
    end
    in_data  = 8'h2E;
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    vecs++;
    if (in_ready !== 1'b0 || grid_valid !== 1'b1 || paper_count !== 9'd256 || mat_flat !== '1) begin
      errs++; $display("FAIL full_hold got rdy=%b gv=%b paper=%0d exp 0 1 256", in_ready, grid_valid, paper_count);
    end
    in_valid = 1'b0;
    pulse_ack();
    vecs++;
    if (grid_valid !== 1'b0 || rows !== 5'd0 || paper_count !== 9'd0 || mat_flat !== '0) begin
      errs++; $display("FAIL full_ack got gv=%b rows=%0d paper=%0d exp 0 0 0", grid_valid, rows, paper_count);
    end
  endtask

  task automatic test_cr_eot();
    logic [7:0] seq [7];
    seq = '{8'h0D, 8'h0A, 8'h40, 8'h2E, 8'h0D, 8'h0A, 8'h04};
    for (int i = 0; i < 7; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      if (i == 3) pulse_ack();
      send_byte(seq[i]);
    end
    vecs++;
    if (grid_valid !== 1'b1 || error !== 1'b0) begin
      errs++; $display("FAIL eot_gv got gv=%b err=%b exp 1 0", grid_valid, error);
    end
    vecs++;
    if (rows !== 5'd1 || cols !== 5'd2 || paper_count !== 9'd1) begin
      errs++; $display("FAIL eot_dims got rows=%0d cols=%0d paper=%0d exp 1 2 1", rows, cols, paper_count);
    end
    vecs++;
    if (mat_flat !== {{(W*D-1){1'b0}}, 1'b1}) begin
      errs++; $display("FAIL eot_mat got %h exp 1", mat_flat);
    end
    pulse_ack();
  endtask

  task automatic test_empty_eot();
    send_byte(8'h0A);
    vecs++;
    if (in_ready !== 1'b1 || error !== 1'b0 || grid_valid !== 1'b0 || rows !== 5'd0) begin
      errs++; $display("FAIL empty_lf got rdy=%b err=%b gv=%b rows=%0d exp 1 0 0 0", in_ready, error, grid_valid, rows);
    end
    send_byte(8'h04);
    vecs++;
    if (error !== 1'b1 || grid_valid !== 1'b0) begin
      errs++; $display("FAIL empty_eot got err=%b gv=%b exp 1 0", error, grid_valid);
    end
    pulse_ack();
    send_byte(8'h41);
    vecs++;
    if (error !== 1'b1) begin errs++; $display("FAIL bad_byte got err=%b exp 1", error); end
    pulse_ack();
  endtask

  task automatic test_reset_midload();
    send_str("@.@.@");
    vecs++;
    if (paper_count !== 9'd3) begin errs++; $display("FAIL mid_paper got %0d exp 3", paper_count); end
    rst_n = 1'b0;
    @(negedge clk);
    vecs++;
    if (mat_flat !== '0 || {rows, cols, paper_count} !== 19'd0 || {grid_valid, error, in_ready} !== 3'b001) begin
      errs++; $display("FAIL mid_rst got paper=%0d flags=%b exp 0 001", paper_count, {grid_valid, error, in_ready});
    end
    rst_n = 1'b1;
    test_basic("reload");
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    grid_ack = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic("basic");
    test_ragged();
    test_overflow();
    test_full();
    test_cr_eot();
    test_empty_eot();
    test_reset_midload();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
